// File: rtl/matrix_inv_seq.sv
// Sequential 2x2 fixed-point matrix inverse / adjugate unit.
// One shared restoring divider produces the four inverse elements in turn.
module matrix_inv_seq #(
  parameter int W     = 16,
  parameter int F     = 14,
  parameter int ROUND = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] a_inv,
  output logic signed [W-1:0] b_inv,
  output logic signed [W-1:0] c_inv,
  output logic signed [W-1:0] d_inv,
  output logic signed [2*W:0] det_out,
  output logic                busy,
  output logic                ready,
  output logic                err_sing,
  output logic                err_ovf
);

  localparam int N  = W + 2 * F;
  localparam int MW = 2 * W + 1;
  localparam int DW = N + MW;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]       CLAST = CW'(N - 1);
  localparam logic [N-1:0]        QPOS  = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [N-1:0]        QNEG  = QPOS + {{(N-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] SMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, DET, DIV, OUT} state_t;

  state_t              state;
  logic signed [W-1:0] a_r, b_r, c_r, d_r;
  logic                mode_r;
  logic signed [2*W:0] det_r;
  logic [1:0]          slot;
  logic [CW-1:0]       cnt;
  logic [MW-1:0]       rem;
  logic [N-1:0]        quo;
  logic                qneg;
  logic                ovf_acc;
  logic signed [W-1:0] res [0:3];

  logic signed [2*W:0] ax, bx, cx, dx, det_c, det_use;
  logic                det_neg;
  logic [MW-1:0]       det_mag;
  logic [1:0]          nslot;
  logic signed [W-1:0] num;
  logic                num_neg;
  logic [W-1:0]        num_mag;
  logic [DW-1:0]       dividend;
  logic [MW:0]         diff;
  logic                ge;
  logic [MW-1:0]       rem_n;
  logic [N-1:0]        q_fin;
  logic signed [W-1:0] sat_val;
  logic                sat_ovf;
  logic signed [W-1:0] neg_b, neg_c;
  logic                adj_ovf;

  assign ax    = {{(W+1){a_r[W-1]}}, a_r};
  assign bx    = {{(W+1){b_r[W-1]}}, b_r};
  assign cx    = {{(W+1){c_r[W-1]}}, c_r};
  assign dx    = {{(W+1){d_r[W-1]}}, d_r};
  assign det_c = ax * dx - bx * cx;

  // The divider is loaded on the DET edge before det_r exists, so use the live product there.
  assign det_use = (state == DET) ? det_c : det_r;
  assign det_neg = det_use[2*W];
  assign det_mag = det_neg ? -det_use : det_use;

  assign nslot = (state == DIV) ? slot + 2'd1 : 2'd0;

  always_comb begin
    num     = d_r;
    num_neg = d_r[W-1];
    case (nslot)
      2'd1: begin num = b_r; num_neg = !b_r[W-1] && (b_r != '0); end
      2'd2: begin num = c_r; num_neg = !c_r[W-1] && (c_r != '0); end
      2'd3: begin num = a_r; num_neg = a_r[W-1]; end
      default: ;
    endcase
  end

  assign num_mag  = num[W-1] ? -num : num;
  assign dividend = ({{(DW-W){1'b0}}, num_mag} << (2 * F))
                  + ((ROUND != 0) ? {{(DW-MW){1'b0}}, det_mag >> 1} : {DW{1'b0}});

  // rem < |det| always holds, so the borrow bit of the trial subtraction is the compare result.
  assign diff  = {rem, quo[N-1]} - {1'b0, det_mag};
  assign ge    = !diff[MW];
  assign rem_n = ge ? diff[MW-1:0] : {rem[MW-2:0], quo[N-1]};
  assign q_fin = {quo[N-2:0], ge};

  always_comb begin
    sat_val = $signed(q_fin[W-1:0]);
    sat_ovf = 1'b0;
    if (qneg) begin
      if (q_fin > QNEG) begin
        sat_val = SMIN;
        sat_ovf = 1'b1;
      end else begin
        sat_val = -$signed(q_fin[W-1:0]);
      end
    end else if (q_fin > QPOS) begin
      sat_val = SMAX;
      sat_ovf = 1'b1;
    end
  end

  assign neg_b   = (b_r == SMIN) ? SMAX : -b_r;
  assign neg_c   = (c_r == SMIN) ? SMAX : -c_r;
  assign adj_ovf = (b_r == SMIN) || (c_r == SMIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      d_r      <= '0;
      mode_r   <= 1'b0;
      det_r    <= '0;
      slot     <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      qneg     <= 1'b0;
      ovf_acc  <= 1'b0;
      for (int i = 0; i < 4; i++) res[i] <= '0;
      a_inv    <= '0;
      b_inv    <= '0;
      c_inv    <= '0;
      d_inv    <= '0;
      det_out  <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      err_sing <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            c_r    <= c;
            d_r    <= d;
            mode_r <= mode;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: state <= DET;
        DET: begin
          det_r <= det_c;
          if (mode_r || (det_c == '0)) begin
            state    <= OUT;
            ready    <= 1'b1;
            det_out  <= det_c;
            err_sing <= !mode_r;
            if (mode_r) begin
              a_inv   <= d_r;
              b_inv   <= neg_b;
              c_inv   <= neg_c;
              d_inv   <= a_r;
              err_ovf <= adj_ovf;
            end else begin
              a_inv   <= '0;
              b_inv   <= '0;
              c_inv   <= '0;
              d_inv   <= '0;
              err_ovf <= 1'b0;
            end
          end else begin
            state   <= DIV;
            slot    <= 2'd0;
            cnt     <= '0;
            rem     <= dividend[DW-1:N];
            quo     <= dividend[N-1:0];
            qneg    <= num_neg ^ det_neg;
            ovf_acc <= 1'b0;
          end
        end
        DIV: begin
          if (cnt == CLAST) begin
            res[slot] <= sat_val;
            ovf_acc   <= ovf_acc | sat_ovf;
            if (slot == 2'd3) begin
              state    <= OUT;
              ready    <= 1'b1;
              a_inv    <= res[0];
              b_inv    <= res[1];
              c_inv    <= res[2];
              d_inv    <= sat_val;
              det_out  <= det_r;
              err_sing <= 1'b0;
              err_ovf  <= ovf_acc | sat_ovf;
            end else begin
              slot <= nslot;
              cnt  <= '0;
              rem  <= dividend[DW-1:N];
              quo  <= dividend[N-1:0];
              qneg <= num_neg ^ det_neg;
            end
          end else begin
            cnt <= cnt + CW'(1);
            rem <= rem_n;
            quo <= q_fin;
          end
        end
        OUT: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
